// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: FSM states, optypes,
// register/word widths and small decode helpers.
package mem_access_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_RESP = 2'd2
  } ma_state_e;

  typedef enum logic [1:0] {
    I_ALU   = 2'd0,
    I_LOAD  = 2'd1,
    I_STORE = 2'd2,
    I_ILL   = 2'd3
  } optype_e;

  function automatic optype_e op_decode(
    input logic ld,
    input logic st
  );
    optype_e t;
    t = I_ALU;
    if (ld && st)
      t = I_ILL;
    else if (ld)
      t = I_LOAD;
    else if (st)
      t = I_STORE;
    return t;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory stage LSU: ALU pass-through, LW/SW via req/gnt/rvalid, stall.
// Ports: ex_* in, stall, dmem_* handshake, wb_* out, err. Macro: MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_load_en,
  input  logic              ex_store_en,
  input  logic              ex_write_reg,
  input  logic [4:0]        ex_rd,
  input  logic [31:0]       ex_res,
  input  logic [31:0]       ex_store_data,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err
);

  ma_state_e              r_state;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_we;
  logic [REG_IDX_W-1:0]   r_rd;
  logic                   r_wb_valid;
  logic                   r_wb_we;
  logic [REG_IDX_W-1:0]   r_wb_rd;
  logic [XLEN-1:0]        r_wb_data;
  logic                   r_err;

  optype_e w_op;
  logic    w_mis;
  logic    w_alu;
  logic    w_ill;
  logic    w_bad;
  logic    w_mem;

  assign w_op = op_decode(ex_load_en, ex_store_en);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign w_mis = misaligned(ex_res[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_alu = ex_valid && (w_op == I_ALU);
  assign w_ill = ex_valid && (w_op == I_ILL);
  assign w_bad = ex_valid && w_mis &&
                 ((w_op == I_LOAD) || (w_op == I_STORE));
  assign w_mem = ex_valid && !w_mis &&
                 ((w_op == I_LOAD) || (w_op == I_STORE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MA_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        MA_IDLE: begin
          unique case (1'b1)
            w_alu: begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= ex_write_reg;
              r_wb_rd    <= ex_rd;
              r_wb_data  <= ex_res;
            end
            w_ill, w_bad: begin
              r_err <= 1'b1;
            end
            w_mem: begin
              r_addr  <= ex_res[ADDR_W-1:0];
              r_wdata <= ex_store_data[DATA_W-1:0];
              r_we    <= (w_op == I_STORE);
              r_rd    <= ex_rd;
              r_state <= MA_REQ;
            end
            default: ;
          endcase
        end
        MA_REQ: begin
          if (dmem_gnt) begin
            if (r_we) begin
              // store completes on grant; rd/data keep last values
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b0;
              r_state    <= MA_IDLE;
            end else begin
              r_state <= MA_RESP;
            end
          end
        end
        MA_RESP: begin
          if (dmem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= 32'(dmem_rdata);
            r_state    <= MA_IDLE;
          end
        end
        default: r_state <= MA_IDLE;
      endcase
    end
  end

  // decoded from state only, so reset drops them at once
  assign stall      = (r_state != MA_IDLE);
  assign dmem_req   = (r_state == MA_REQ);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_we      = r_wb_we;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access with a transaction-level model
// (word memory map, last writeback values, expected error rule).
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_load_en = 1'b0;
  logic        ex_store_en = 1'b0;
  logic        ex_write_reg = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_res = '0;
  logic [31:0] ex_store_data = '0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [logic [31:0]];
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_ILL = 3;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load_en(ex_load_en),
    .ex_store_en(ex_store_en), .ex_write_reg(ex_write_reg),
    .ex_rd(ex_rd), .ex_res(ex_res), .ex_store_data(ex_store_data),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    ex_valid      = 1'b0;
    ex_load_en    = 1'($urandom);
    ex_store_en   = 1'($urandom);
    ex_res        = $urandom;
    ex_rd         = 5'($urandom);
    cyc();
    chk("idle_wbv", wb_valid, 0);
    chk("idle_err", err, 0);
    chk("idle_req", dmem_req, 0);
    chk("idle_rd", wb_rd, last_rd);
    chk("idle_data", wb_data, last_data);
  endtask

  // one transaction from IDLE; hold keeps ex_* asserted while stalled
  task automatic txn(input int kind, input logic [31:0] a,
                     input logic [4:0] rd, input logic wr,
                     input logic [31:0] sd, input int gd,
                     input int rl, input bit hold);
    logic bad;
    logic [31:0] rv;
    chk("pre_stall", stall, 0);
    ex_valid      = 1'b1;
    ex_load_en    = (kind == K_LD) || (kind == K_ILL);
    ex_store_en   = (kind == K_ST) || (kind == K_ILL);
    ex_write_reg  = wr;
    ex_rd         = rd;
    ex_res        = a;
    ex_store_data = sd;
    bad = (kind == K_ILL) ||
          (ALIGN && kind != K_ALU && a[1:0] != 2'b00);
    cyc();
    if (!hold || kind == K_ALU || bad) ex_valid = 1'b0;
    if (kind == K_ALU) begin
      chk("alu_wbv", wb_valid, 1);
      chk("alu_we", wb_we, wr);
      chk("alu_rd", wb_rd, rd);
      chk("alu_data", wb_data, a);
      chk("alu_stall", stall, 0);
      last_rd = rd;
      last_data = a;
    end else if (bad) begin
      chk("bad_err", err, 1);
      chk("bad_wbv", wb_valid, 0);
      chk("bad_req", dmem_req, 0);
      chk("bad_stall", stall, 0);
    end else begin
      chk("req", dmem_req, 1);
      chk("req_we", dmem_we, kind == K_ST);
      chk("req_addr", dmem_addr, a);
      chk("req_stall", stall, 1);
      chk("req_wbv", wb_valid, 0);
      if (kind == K_ST) chk("req_wdata", dmem_wdata, sd);
      for (int k = 0; k < gd; k++) begin
        cyc();
        chk("bp_req", dmem_req, 1);
        chk("bp_addr", dmem_addr, a);
        chk("bp_we", dmem_we, kind == K_ST);
        if (kind == K_ST) chk("bp_wdata", dmem_wdata, sd);
        chk("bp_wbv", wb_valid, 0);
      end
      dmem_gnt = 1'b1;
      cyc();
      dmem_gnt = 1'b0;
      if (kind == K_ST) begin
        ex_valid = 1'b0;
        mem[a] = sd;
        chk("st_wbv", wb_valid, 1);
        chk("st_we", wb_we, 0);
        chk("st_req", dmem_req, 0);
        chk("st_stall", stall, 0);
      end else begin
        chk("resp_req", dmem_req, 0);
        chk("resp_stall", stall, 1);
        chk("resp_wbv", wb_valid, 0);
        for (int k = 0; k < rl; k++) begin
          dmem_rdata = $urandom;
          cyc();
          chk("rl_wbv", wb_valid, 0);
          chk("rl_stall", stall, 1);
        end
        rv = mem_rd(a);
        dmem_rvalid = 1'b1;
        dmem_rdata = rv;
        cyc();
        dmem_rvalid = 1'b0;
        ex_valid = 1'b0;
        chk("ld_wbv", wb_valid, 1);
        chk("ld_we", wb_we, 1);
        chk("ld_rd", wb_rd, rd);
        chk("ld_data", wb_data, rv);
        chk("ld_stall", stall, 0);
        last_rd = rd;
        last_data = rv;
      end
    end
    if (hold) idle_cyc();
  endtask

  initial begin
    int r;
    int kind;
    logic [31:0] a;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_addr", dmem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(K_ALU, 32'h2A, 5'd5, 1'b1, 0, 0, 0, 0);
    mem[32'h100] = 32'hDEAD_BEEF;
    txn(K_LD, 32'h100, 5'd7, 1'b1, 0, 0, 0, 0);
    txn(K_ST, 32'h200, 5'd0, 1'b0, 32'h1234_5678, 4, 0, 1);
    txn(K_ILL, 32'h10, 5'd3, 1'b1, 0, 0, 0, 0);
    txn(K_LD, 32'h102, 5'd4, 1'b1, 0, 1, 1, 0);

    // load followed by an ADD held during the stall
    ex_valid = 1'b1; ex_load_en = 1'b1; ex_store_en = 1'b0;
    ex_write_reg = 1'b1; ex_rd = 5'd7; ex_res = 32'h200;
    cyc();
    ex_load_en = 1'b0; ex_rd = 5'd2; ex_res = 32'd3;
    chk("b2b_req", dmem_req, 1);
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    chk("b2b_wait", wb_valid, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata = mem_rd(32'h200);
    cyc();
    dmem_rvalid = 1'b0;
    chk("b2b_ld_wbv", wb_valid, 1);
    chk("b2b_ld_rd", wb_rd, 7);
    chk("b2b_ld_data", wb_data, 32'h1234_5678);
    cyc();
    ex_valid = 1'b0;
    chk("b2b_add_wbv", wb_valid, 1);
    chk("b2b_add_rd", wb_rd, 2);
    chk("b2b_add_data", wb_data, 3);
    last_rd = 5'd2;
    last_data = 32'd3;
    idle_cyc();

    // reset while waiting for read data
    ex_valid = 1'b1; ex_load_en = 1'b1; ex_store_en = 1'b0;
    ex_rd = 5'd9; ex_res = 32'h300;
    cyc();
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    chk("rr_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_stall", stall, 0);
    chk("rr_req", dmem_req, 0);
    chk("rr_wbv", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    last_data = '0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    cyc();
    dmem_rvalid = 1'b0;
    chk("rr_ignore_wbv", wb_valid, 0);
    chk("rr_ignore_data", wb_data, 0);
    idle_cyc();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      kind = (r < 4) ? K_ALU : (r < 6) ? K_LD :
             (r < 8) ? K_ST : (r == 8) ? K_ILL : -1;
      a = {22'd0, 8'($urandom), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (kind == K_ALU) a = $urandom;
      if (kind < 0)
        idle_cyc();
      else
        txn(kind, a, 5'($urandom), 1'($urandom), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage load/store unit. Consumes the execute stage's `res`, `write_reg`, `load_en` and `store_en` outputs and drives a word-wide data-memory request/grant/response handshake.
- Delivers writeback data, or passes non-memory results through.
- Holds the pipeline with `stall` while a memory transaction is outstanding.

Parameters:
- `ADDR_W`, 32, data-memory address width (low `ADDR_W` bits of `ex_res`).
- `DATA_W`, 32, data word width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  execute-stage output valid this cycle.
- `ex_load_en`  in  1  instruction is a load (LW).
- `ex_store_en`  in  1  instruction is a store (SW).
- `ex_write_reg`  in  1  instruction writes rd.
- `ex_rd`  in  5  destination register index.
- `ex_res`  in  32  ALU result; effective address when load/store.
- `ex_store_data`  in  32  store data (rs2 value).
- `stall`  out  1  high = `ex_*` not accepted this cycle; upstream holds.
- `dmem_req`  out  1  memory request valid.
- `dmem_we`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  `ADDR_W`  word address (byte address, bits [1:0] = 0 when aligned).
- `dmem_wdata`  out  `DATA_W`  write data.
- `dmem_gnt`  in  1  memory accepted request.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  `DATA_W`  read data.
- `wb_valid`  out  1  writeback bundle valid (1-cycle pulse).
- `wb_we`  out  1  writeback writes rd.
- `wb_rd`  out  5  writeback register index.
- `wb_data`  out  32  writeback value.
- `err`  out  1  1-cycle pulse: illegal load+store combination or misaligned access.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE. All outputs 0, captured registers cleared. Deassertion is synchronous to `clk`.
- FSM states: IDLE, REQ, RESP.
- `stall` = (state != IDLE). Combinational from state only; no combinational path from `dmem_*`.
- IDLE, `ex_valid`=1, no load/store: next cycle `wb_valid`=1, `wb_we`=`ex_write_reg`, `wb_rd`=`ex_rd`, `wb_data`=`ex_res`. Latency 1. Stay IDLE.
- IDLE, `ex_valid`=1, load or store:
  - Capture addr, data, rd, and type.
  - Go to REQ.
  - `wb_valid`=0 next cycle.
- IDLE, `ex_load_en` & `ex_store_en` both 1:
  - Treat as no-op: `err` pulse next cycle, `wb_valid`=0, no memory access.
- REQ: `dmem_req`=1 and `dmem_addr`/`dmem_we`/`dmem_wdata` stable until `dmem_gnt`.
  - On gnt, store: `dmem_req` drops next cycle; next cycle `wb_valid`=1, `wb_we`=0; go to IDLE.
  - On gnt, load: go to RESP.
- RESP: `dmem_req`=0.
  - On `dmem_rvalid`: next cycle `wb_valid`=1, `wb_we`=1, `wb_rd`=captured rd, `wb_data`=`dmem_rdata`; go to IDLE.
  - `dmem_rvalid` in the same cycle as `dmem_gnt` is not supported; memory returns data ≥1 cycle after gnt.
- `dmem_rvalid` outside RESP: ignored.
- Minimum load latency: accept → `wb_valid` = 3 cycles (gnt and rvalid each 1 cycle later). Minimum store latency: 2 cycles.
- `ex_valid`=0 in IDLE: `wb_valid`=0.
- `wb_*` registered. `wb_data`/`wb_rd` hold their last value when `wb_valid`=0.
- Reset mid-transaction: FSM returns to IDLE, `dmem_req` drops asynchronously, and the outstanding response is discarded.

Optional Feature:
- Macro: `MEM_ACCESS_ALIGN_CHECK_EN`.
- Defined: a load/store with `ex_res[1:0]` != 0 is not issued. Next cycle: `err`=1, `wb_valid`=0. Stay IDLE.
- Undefined: the address passes unmodified; alignment is the memory's concern, and `err` fires only for load+store.

Decomposition:
- Shared package/header (alongside the existing `I_*` optype defines):
  - state encoding `MA_IDLE`/`MA_REQ`/`MA_RESP` (2 bits);
  - `REG_IDX_W`=5;
  - `XLEN`=32.
- Single flat module; no sub-module is natural (FSM plus capture registers).

Test Plan:
- ALU pass-through: `ex_valid`=1, `write_reg`=1, `rd`=5, `res`=0x0000_002A, no load/store → next cycle `wb_valid`=1, `wb_we`=1, `wb_rd`=5, `wb_data`=0x2A; `stall` never high.
- Load, zero wait: load addr 0x100, `rd`=7; gnt 1 cycle after `req`; rvalid next cycle with 0xDEAD_BEEF → `dmem_req`=1, `dmem_we`=0, addr 0x100 for exactly 1 cycle; `wb_valid` with `rd`=7, data 0xDEADBEEF; `stall` high 2 cycles.
- Store with backpressure: store addr 0x200, data 0x1234_5678, gnt withheld 4 cycles → `req`/addr/data stable all 5 cycles; then `wb_valid`=1, `wb_we`=0; upstream inputs held and not re-accepted.
- Back-to-back: load immediately followed by an ADD (`res`=3, `rd`=2) held during stall → ADD is accepted only after the load's `wb_valid`; two `wb_valid` pulses, in order.
- Illegal load+store: both set, addr 0x10 → `err` pulse, no `dmem_req`, `wb_valid`=0.
- Reset in RESP: assert `rst_n`=0 while awaiting rvalid → `dmem_req`, `wb_valid` and `stall` are 0 immediately; a later rvalid is ignored.
- With `MEM_ACCESS_ALIGN_CHECK_EN`: load addr 0x102 → `err`=1, no `dmem_req`.
